// File: rtl/rr_request_mux.sv
// Two-input round-robin request merger.
// Each port buffers (address, id) requests in its own FIFO. One request per cycle is granted
// into a registered output stage that drives the shared resource. The output carries the
// source port so that responses can be attributed to the right pipeline.
module rr_request_mux #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned ID_W   = 8,
   parameter int unsigned DEPTH  = 2
) (
   input  logic              clk,
   input  logic              reset,
   // port 1 (pipeline_1)
   input  logic [ADDR_W-1:0] in_address_1,
   input  logic [ID_W-1:0]   in_id_1,
   input  logic              in_valid_1,
   output logic              out_stall_1,
   // port 2 (pipeline_2)
   input  logic [ADDR_W-1:0] in_address_2,
   input  logic [ID_W-1:0]   in_id_2,
   input  logic              in_valid_2,
   output logic              out_stall_2,
   // merged stream (shared_resource)
   output logic [ADDR_W-1:0] out_address,
   output logic [ID_W-1:0]   out_id,
   output logic              out_src,
   output logic              out_valid,
   input  logic              in_stall
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = $clog2(DEPTH + 1);
   localparam logic [CntW-1:0] CountFull = CntW'(DEPTH);

   // last_grant encoding: 0 = port 1, 1 = port 2
   localparam logic SrcPort1 = 1'b0;
   localparam logic SrcPort2 = 1'b1;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [ID_W-1:0]   id;
   } req_t;

   // FIFO storage and bookkeeping, port 1
   req_t            mem_1_q [DEPTH];
   logic [PtrW-1:0] wr_ptr_1_q, wr_ptr_1_d;
   logic [PtrW-1:0] rd_ptr_1_q, rd_ptr_1_d;
   logic [CntW-1:0] count_1_q, count_1_d;

   // FIFO storage and bookkeeping, port 2
   req_t            mem_2_q [DEPTH];
   logic [PtrW-1:0] wr_ptr_2_q, wr_ptr_2_d;
   logic [PtrW-1:0] rd_ptr_2_q, rd_ptr_2_d;
   logic [CntW-1:0] count_2_q, count_2_d;

   // output stage and arbitration state
   req_t out_req_q, out_req_d;
   logic out_src_q, out_src_d;
   logic out_valid_q, out_valid_d;
   logic last_grant_q, last_grant_d;

   logic full_1, full_2;
   logic empty_1, empty_2;
   logic push_1, push_2;
   logic pop_1, pop_2;
   logic load;

   // Status decoded from registered counts only, so stalls never depend on in_valid/in_stall.
   always_comb begin
      full_1  = (count_1_q == CountFull);
      full_2  = (count_2_q == CountFull);
      empty_1 = (count_1_q == '0);
      empty_2 = (count_2_q == '0);
      push_1  = in_valid_1 && !full_1;
      push_2  = in_valid_2 && !full_2;
   end

   // Round-robin grant into the output register; the loser of a tie is favoured next time.
   always_comb begin
      load         = !out_valid_q || !in_stall;
      pop_1        = 1'b0;
      pop_2        = 1'b0;
      out_req_d    = out_req_q;
      out_src_d    = out_src_q;
      out_valid_d  = out_valid_q;
      last_grant_d = last_grant_q;
      if (load) begin
         if (!empty_1 && (empty_2 || (last_grant_q == SrcPort2))) begin
            pop_1        = 1'b1;
            out_req_d    = mem_1_q[rd_ptr_1_q];
            out_src_d    = SrcPort1;
            out_valid_d  = 1'b1;
            last_grant_d = SrcPort1;
         end else if (!empty_2) begin
            pop_2        = 1'b1;
            out_req_d    = mem_2_q[rd_ptr_2_q];
            out_src_d    = SrcPort2;
            out_valid_d  = 1'b1;
            last_grant_d = SrcPort2;
         end else begin
            // nothing pending: drop valid, leave the stale payload in place
            out_valid_d = 1'b0;
         end
      end
   end

   // FIFO pointer and occupancy next state, port 1
   always_comb begin
      wr_ptr_1_d = wr_ptr_1_q;
      rd_ptr_1_d = rd_ptr_1_q;
      count_1_d  = count_1_q;
      if (push_1) begin
         wr_ptr_1_d = wr_ptr_1_q + 1'b1;
      end
      if (pop_1) begin
         rd_ptr_1_d = rd_ptr_1_q + 1'b1;
      end
      unique case ({push_1, pop_1})
         2'b10:   count_1_d = count_1_q + 1'b1;
         2'b01:   count_1_d = count_1_q - 1'b1;
         default: count_1_d = count_1_q;
      endcase
   end

   // FIFO pointer and occupancy next state, port 2
   always_comb begin
      wr_ptr_2_d = wr_ptr_2_q;
      rd_ptr_2_d = rd_ptr_2_q;
      count_2_d  = count_2_q;
      if (push_2) begin
         wr_ptr_2_d = wr_ptr_2_q + 1'b1;
      end
      if (pop_2) begin
         rd_ptr_2_d = rd_ptr_2_q + 1'b1;
      end
      unique case ({push_2, pop_2})
         2'b10:   count_2_d = count_2_q + 1'b1;
         2'b01:   count_2_d = count_2_q - 1'b1;
         default: count_2_d = count_2_q;
      endcase
   end

   // FIFO payload storage; contents need no reset since pointers gate every read
   always_ff @(posedge clk) begin
      if (push_1) begin
         mem_1_q[wr_ptr_1_q] <= '{addr: in_address_1, id: in_id_1};
      end
      if (push_2) begin
         mem_2_q[wr_ptr_2_q] <= '{addr: in_address_2, id: in_id_2};
      end
   end

   // Control state; reset discards everything buffered or in flight
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_1_q   <= '0;
         rd_ptr_1_q   <= '0;
         count_1_q    <= '0;
         wr_ptr_2_q   <= '0;
         rd_ptr_2_q   <= '0;
         count_2_q    <= '0;
         out_req_q    <= '0;
         out_src_q    <= SrcPort1;
         out_valid_q  <= 1'b0;
         last_grant_q <= SrcPort2;
      end else begin
         wr_ptr_1_q   <= wr_ptr_1_d;
         rd_ptr_1_q   <= rd_ptr_1_d;
         count_1_q    <= count_1_d;
         wr_ptr_2_q   <= wr_ptr_2_d;
         rd_ptr_2_q   <= rd_ptr_2_d;
         count_2_q    <= count_2_d;
         out_req_q    <= out_req_d;
         out_src_q    <= out_src_d;
         out_valid_q  <= out_valid_d;
         last_grant_q <= last_grant_d;
      end
   end

   // Output drive straight from registers
   always_comb begin
      out_address = out_req_q.addr;
      out_id      = out_req_q.id;
      out_src     = out_src_q;
      out_valid   = out_valid_q;
      out_stall_1 = full_1;
      out_stall_2 = full_2;
   end

`ifndef SYNTHESIS
   // A held request must stay bit-stable while downstream stalls.
   a_hold_stable: assert property (@(posedge clk) disable iff (reset)
      (out_valid_q && in_stall) |=> (out_valid_q && $stable(out_req_q) && $stable(out_src_q)));

   // FIFOs never underflow or overflow.
   a_no_underflow: assert property (@(posedge clk) disable iff (reset)
      !((pop_1 && empty_1) || (pop_2 && empty_2)));
   a_no_overflow: assert property (@(posedge clk) disable iff (reset)
      !((push_1 && full_1) || (push_2 && full_2)));
`endif

endmodule

// File: tb/tb_rr_request_mux.sv
// Self-checking bench for rr_request_mux: transaction model plus scoreboard of expected outputs,
// directed scenarios followed by random traffic.
module tb_rr_request_mux;

   localparam int unsigned ADDR_W = 16;
   localparam int unsigned ID_W   = 8;
   localparam int unsigned DEPTH  = 2;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [ID_W-1:0]   id;
   } req_t;

   typedef struct packed {
      logic              src;
      logic [ADDR_W-1:0] addr;
      logic [ID_W-1:0]   id;
   } out_t;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic [ADDR_W-1:0] in_address_1 = '0, in_address_2 = '0;
   logic [ID_W-1:0]   in_id_1 = '0, in_id_2 = '0;
   logic              in_valid_1 = 1'b0, in_valid_2 = 1'b0;
   logic              out_stall_1, out_stall_2;
   logic [ADDR_W-1:0] out_address;
   logic [ID_W-1:0]   out_id;
   logic              out_src, out_valid;
   logic              in_stall = 1'b0;

   always #5 clk = ~clk;

   rr_request_mux #(
      .ADDR_W (ADDR_W),
      .ID_W   (ID_W),
      .DEPTH  (DEPTH)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .in_address_1 (in_address_1),
      .in_id_1      (in_id_1),
      .in_valid_1   (in_valid_1),
      .out_stall_1  (out_stall_1),
      .in_address_2 (in_address_2),
      .in_id_2      (in_id_2),
      .in_valid_2   (in_valid_2),
      .out_stall_2  (out_stall_2),
      .out_address  (out_address),
      .out_id       (out_id),
      .out_src      (out_src),
      .out_valid    (out_valid),
      .in_stall     (in_stall)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // stimulus waiting to be offered, model FIFOs, scoreboard of granted requests
   req_t stim1_q[$], stim2_q[$];
   req_t mq1[$], mq2[$];
   out_t exp_q[$];
   logic m_last;

   // per-cycle DUT observations for directed checks
   logic obs_valid, obs_stall1, obs_stall2;
   out_t obs_out;
   logic cons_src[$];
   logic [ID_W-1:0] cons_id[$];

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock cycle: check DUT against model, drive this cycle's inputs, advance the model.
   task automatic cycle(input logic stall);
      req_t r;
      logic m_valid, load, acc1, acc2;
      @(negedge clk);
      m_valid = (exp_q.size() != 0);
      check_eq("out_valid", out_valid, m_valid);
      check_eq("out_stall_1", out_stall_1, mq1.size() == DEPTH);
      check_eq("out_stall_2", out_stall_2, mq2.size() == DEPTH);
      if (m_valid) check_eq("out_payload", {out_src, out_address, out_id}, exp_q[0]);
      obs_valid  = out_valid;
      obs_stall1 = out_stall_1;
      obs_stall2 = out_stall_2;
      obs_out    = {out_src, out_address, out_id};
      if (out_valid && !stall) begin
         cons_src.push_back(out_src);
         cons_id.push_back(out_id);
      end

      in_stall   = stall;
      in_valid_1 = (stim1_q.size() != 0);
      in_valid_2 = (stim2_q.size() != 0);
      r = in_valid_1 ? stim1_q[0] : req_t'($urandom);
      in_address_1 = r.addr;
      in_id_1      = r.id;
      r = in_valid_2 ? stim2_q[0] : req_t'($urandom);
      in_address_2 = r.addr;
      in_id_2      = r.id;

      acc1 = in_valid_1 && (mq1.size() != DEPTH);
      acc2 = in_valid_2 && (mq2.size() != DEPTH);
      load = !m_valid || !stall;
      if (m_valid && !stall) void'(exp_q.pop_front());
      if (load) begin
         if (mq1.size() != 0 && (mq2.size() == 0 || m_last == 1'b1)) begin
            r = mq1.pop_front();
            exp_q.push_back({1'b0, r});
            m_last = 1'b0;
         end else if (mq2.size() != 0) begin
            r = mq2.pop_front();
            exp_q.push_back({1'b1, r});
            m_last = 1'b1;
         end
      end
      if (acc1) mq1.push_back(stim1_q.pop_front());
      if (acc2) mq2.push_back(stim2_q.pop_front());
   endtask

   // Mid-cycle asynchronous reset; outputs must clear before any clock edge.
   task automatic do_reset();
      @(negedge clk);
      #2;
      reset      = 1'b1;
      in_valid_1 = 1'b0;
      in_valid_2 = 1'b0;
      in_stall   = 1'b0;
      #1;
      check_eq("rst_out_valid", out_valid, 0);
      check_eq("rst_out_stall_1", out_stall_1, 0);
      check_eq("rst_out_stall_2", out_stall_2, 0);
      check_eq("rst_out_payload", {out_src, out_address, out_id}, 0);
      stim1_q.delete();
      stim2_q.delete();
      mq1.delete();
      mq2.delete();
      exp_q.delete();
      cons_src.delete();
      cons_id.delete();
      m_last = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   int run, max_run, n_src2;
   logic saw_stall1, saw_stall2;
   logic stall_r;
   logic [ADDR_W-1:0] seq;

   initial begin
      m_last = 1'b1;
      seq    = 16'h1000;

      // single request: visible in cycle 2 only
      do_reset();
      stim1_q.push_back('{addr: 16'h0010, id: 8'd3});
      cycle(1'b0);
      cycle(1'b0);
      check_eq("single_c1_valid", obs_valid, 0);
      cycle(1'b0);
      check_eq("single_c2_valid", obs_valid, 1);
      check_eq("single_c2_payload", obs_out, {1'b0, 16'h0010, 8'd3});
      cycle(1'b0);
      check_eq("single_c3_valid", obs_valid, 0);

      // contention: strict alternation, per-port order
      do_reset();
      for (int i = 1; i <= 3; i++) begin
         stim1_q.push_back('{addr: ADDR_W'(16'h0100 + i), id: ID_W'(i)});
         stim2_q.push_back('{addr: ADDR_W'(16'h0200 + i), id: ID_W'(i)});
      end
      repeat (10) cycle(1'b0);
      check_eq("contend_count", cons_src.size(), 6);
      for (int i = 0; i < 6 && i < cons_src.size(); i++) begin
         check_eq("contend_src", cons_src[i], i % 2);
         check_eq("contend_id", cons_id[i], (i / 2) + 1);
      end

      // back-pressure: downstream stalled for cycles 3..7
      do_reset();
      for (int i = 0; i < 8; i++) begin
         stim1_q.push_back('{addr: ADDR_W'(16'h0300 + i), id: ID_W'(i)});
         stim2_q.push_back('{addr: ADDR_W'(16'h0400 + i), id: ID_W'(8'h80 + i)});
      end
      saw_stall1 = 1'b0;
      saw_stall2 = 1'b0;
      for (int c = 0; c < 30; c++) begin
         cycle(c >= 3 && c <= 7);
         saw_stall1 |= obs_stall1;
         saw_stall2 |= obs_stall2;
      end
      check_eq("bp_saw_stall_1", saw_stall1, 1);
      check_eq("bp_saw_stall_2", saw_stall2, 1);
      check_eq("bp_consumed", cons_src.size(), 16);

      // solo stream on port 2: eight back-to-back outputs
      do_reset();
      for (int i = 0; i < 8; i++) begin
         stim2_q.push_back('{addr: ADDR_W'(16'h0500 + i), id: ID_W'(i)});
      end
      run     = 0;
      max_run = 0;
      n_src2  = 0;
      repeat (14) begin
         cycle(1'b0);
         run = obs_valid ? run + 1 : 0;
         if (run > max_run) max_run = run;
         if (obs_valid && obs_out.src) n_src2++;
      end
      check_eq("solo_run", max_run, 8);
      check_eq("solo_src2", n_src2, 8);

      // reset with both FIFOs full and downstream stalled
      do_reset();
      for (int i = 0; i < 6; i++) begin
         stim1_q.push_back('{addr: ADDR_W'(16'h0600 + i), id: ID_W'(i)});
         stim2_q.push_back('{addr: ADDR_W'(16'h0700 + i), id: ID_W'(i)});
      end
      repeat (8) cycle(1'b1);
      cycle(1'b1);
      check_eq("full_stall_1", obs_stall1, 1);
      check_eq("full_stall_2", obs_stall2, 1);
      check_eq("full_valid", obs_valid, 1);
      do_reset();
      cycle(1'b0);
      check_eq("post_rst_valid", obs_valid, 0);
      check_eq("post_rst_stall_1", obs_stall1, 0);
      check_eq("post_rst_stall_2", obs_stall2, 0);

      // random traffic against the model
      do_reset();
      for (int c = 0; c < 400; c++) begin
         if (stim1_q.size() < 3 && $urandom_range(0, 2) != 0) begin
            stim1_q.push_back('{addr: seq, id: ID_W'($urandom)});
            seq++;
         end
         if (stim2_q.size() < 3 && $urandom_range(0, 2) != 0) begin
            stim2_q.push_back('{addr: seq, id: ID_W'($urandom)});
            seq++;
         end
         stall_r = ($urandom_range(0, 3) == 0);
         cycle(stall_r);
      end
      repeat (20) cycle(1'b0);
      check_eq("drain_valid", obs_valid, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
